tl_sensor_cond: RTL and testbench
=================================

# tl_sensor_cond

Four-channel traffic-sensor conditioner that sits directly upstream of the left-turn traffic-light controller and drives its Ta, Tb, Tal and Tbl inputs. Each raw, asynchronous vehicle-detector line is:
- synchronized into the clk domain,
- debounced, so short glitches are rejected,
- stretched by a minimum hold time, so brief gaps between cars do not make the controller change state early.

All four channels are identical and fully independent.

## Interface
- DEB_CYCLES, 4, consecutive synchronized cycles a new level must persist before the debounced level changes; legal range ≥1.
- HOLD_CYCLES, 8, cycles the output stays high after the debounced level falls; legal range ≥1.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset; clears all state immediately.
- sen_a  input  1  raw detector, street A through lanes; asynchronous.
- sen_b  input  1  raw detector, street B through lanes; asynchronous.
- sen_al  input  1  raw detector, street A left-turn lane; asynchronous.
- sen_bl  input  1  raw detector, street B left-turn lane; asynchronous.
- Ta  output  1  conditioned A traffic present; feeds controller Ta.
- Tb  output  1  conditioned B traffic present; feeds controller Tb.
- Tal  output  1  conditioned A-left traffic present; feeds controller Tal.
- Tbl  output  1  conditioned B-left traffic present; feeds controller Tbl.

## Operation
The behaviour below applies per channel, with raw input x and output T.

Synchronizer
- Two-flop chain s1 → s2.
- Both flops reset to 0.

Debouncer
- Register deb, reset 0, plus a counter dcnt of width $clog2(DEB_CYCLES+1), reset 0.
- When s2 == deb: dcnt ← 0.
- When s2 != deb and dcnt == DEB_CYCLES−1: deb ← s2 and dcnt ← 0.
- Otherwise dcnt ← dcnt+1.
- Any single cycle of agreement restarts the count.

Output FSM
- State register, reset OFF, plus a counter hcnt of width $clog2(HOLD_CYCLES+1), reset 0.
- OFF: T = 0. If deb = 1, go to ON.
- ON: T = 1. If deb = 0, go to HOLD and load hcnt ← HOLD_CYCLES−1.
- HOLD: T = 1.
  - If deb = 1, go to ON (this takes priority).
  - Else if hcnt == 0, go to OFF.
  - Else hcnt ← hcnt−1.
- T is a registered decode of state: T = (state != OFF). There is no combinational path from x to T.
- Unreachable state encodings recover to OFF on the next clock edge.

Boundary rules
- Glitch shorter than DEB_CYCLES synchronized cycles: no change to deb, so no change to T.
- A short high glitch during HOLD does not reload or pause hcnt.
- deb returning to 1 during HOLD returns the FSM to ON. T stays 1 throughout, with no low pulse.
- Reset asserted mid-operation:
  - all outputs go to 0 asynchronously, without waiting for a clock edge;
  - all counters go to 0 and the state goes to OFF.
- After reset deasserts, a raw input that is already high produces T = 1 only after the full latency below.
- The four channels share no state. Simultaneous events on several channels are handled independently in the same cycles.

## Timing
- Edge numbering: edge 1 is the first rising clk edge at which the raw level is sampled stable.
- Rise latency: T rises just after edge DEB_CYCLES+3. With defaults this is edge 7.
- Fall latency: T falls just after edge DEB_CYCLES+3+HOLD_CYCLES, counted from the first edge the raw low is sampled. With defaults this is edge 15.
- Minimum raw pulse width that propagates: DEB_CYCLES clk periods, plus synchronizer uncertainty of ≤1 cycle.
- Every output reset value is 0.
- Throughput: a new level can be accepted every cycle; there is no backpressure.

## Test plan
All scenarios use default parameters, a 10 ns clk period, and inputs changed at negedge.

1. Reset behaviour: hold reset = 1 with all raw inputs = 1 → Ta/Tb/Tal/Tbl = 0. Release reset → all outputs rise together 7 edges later.
2. Glitch rejection: sen_a high for 3 cycles, then low → Ta stays 0 throughout, and the other outputs are unaffected.
3. Hold stretch: sen_b high for 20 cycles, then low →
   - Tb rises after edge 7 of the high;
   - Tb stays 1 for 15 edges after the fall is first sampled;
   - Tb then drops to 0.
4. Gap bridging: sen_al high for 10 cycles, low for 5, then high again → Tal never returns to 0. The FSM follows ON→HOLD→ON.
5. Async reset mid-hold: while Tbl = 1 in HOLD, pulse reset = 1 between clock edges → Tbl = 0 before the next edge. After release with sen_bl = 0, Tbl stays 0.
6. Independence: toggle all four raw inputs with staggered 12-cycle pulses → each output follows its own input exactly, with 7-edge rise and 15-edge fall latency.

Source files
------------

// File: rtl/tl_sensor_cond_if.sv
// Detector inputs and conditioned traffic-present outputs of the sensor conditioner.
// master drives the raw detector lines; slave is the conditioner itself.
interface tl_sensor_cond_if;
  logic sen_a;
  logic sen_b;
  logic sen_al;
  logic sen_bl;
  logic Ta;
  logic Tb;
  logic Tal;
  logic Tbl;

  modport master (
    output sen_a, sen_b, sen_al, sen_bl,
    input  Ta, Tb, Tal, Tbl
  );

  modport slave (
    input  sen_a, sen_b, sen_al, sen_bl,
    output Ta, Tb, Tal, Tbl
  );
endinterface

// File: rtl/tl_sensor_cond.sv
// Four independent detector conditioners: 2-flop synchronizer, debouncer and
// minimum-hold output FSM per channel, feeding the left-turn light controller.
module tl_sensor_cond #(
  parameter int unsigned DEB_CYCLES  = 4,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic              clk,
  input  logic              reset,
  tl_sensor_cond_if.slave   sif
);

  localparam int unsigned DCW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned HCW = $clog2(HOLD_CYCLES + 1);
  localparam logic [DCW-1:0] DebLast  = DCW'(DEB_CYCLES - 1);
  localparam logic [HCW-1:0] HoldLoad = HCW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    StOff  = 2'b00,
    StOn   = 2'b01,
    StHold = 2'b10
  } state_e;

  logic [3:0] raw;
  logic [3:0] t;

  assign raw = {sif.sen_bl, sif.sen_al, sif.sen_b, sif.sen_a};

  assign sif.Ta  = t[0];
  assign sif.Tb  = t[1];
  assign sif.Tal = t[2];
  assign sif.Tbl = t[3];

  for (genvar ch = 0; ch < 4; ch++) begin : g_ch
    logic           s1_q;
    logic           s2_q;
    logic           deb_q;
    logic [DCW-1:0] dcnt_q;
    state_e         state_q;
    logic [HCW-1:0] hcnt_q;
    logic           t_q;

    // Synchronizer and debouncer; any cycle of agreement restarts the count.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        s1_q   <= 1'b0;
        s2_q   <= 1'b0;
        deb_q  <= 1'b0;
        dcnt_q <= '0;
      end else begin
        s1_q <= raw[ch];
        s2_q <= s1_q;
        if (s2_q == deb_q) begin
          dcnt_q <= '0;
        end else if (dcnt_q == DebLast) begin
          deb_q  <= s2_q;
          dcnt_q <= '0;
        end else begin
          dcnt_q <= dcnt_q + DCW'(1);
        end
      end
    end

    // Output FSM; t_q always tracks (state != StOff) so the output is glitch-free.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= StOff;
        hcnt_q  <= '0;
        t_q     <= 1'b0;
      end else begin
        case (state_q)
          StOff: begin
            if (deb_q) begin
              state_q <= StOn;
              t_q     <= 1'b1;
            end else begin
              t_q <= 1'b0;
            end
          end
          StOn: begin
            t_q <= 1'b1;
            if (!deb_q) begin
              state_q <= StHold;
              hcnt_q  <= HoldLoad;
            end
          end
          StHold: begin
            if (deb_q) begin
              state_q <= StOn;
              t_q     <= 1'b1;
            end else if (hcnt_q == '0) begin
              state_q <= StOff;
              t_q     <= 1'b0;
            end else begin
              hcnt_q <= hcnt_q - HCW'(1);
              t_q    <= 1'b1;
            end
          end
          default: begin
            state_q <= StOff;
            hcnt_q  <= '0;
            t_q     <= 1'b0;
          end
        endcase
      end
    end

    assign t[ch] = t_q;
  end

endmodule

// File: tb/tb_tl_sensor_cond.sv
// Scoreboard bench: stimulus pushes the expected outputs for the next edge,
// a monitor pops and compares them after every rising edge.
module tb_tl_sensor_cond;
  localparam int unsigned DEB  = 4;
  localparam int unsigned HOLD = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tl_sensor_cond_if sif ();

  tl_sensor_cond #(
    .DEB_CYCLES (DEB),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .sif  (sif)
  );

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];

  // Reference model: per channel, the synchronized value seen over the last DEB
  // edges and the debounced value over the last HOLD+1 edges.
  bit s2h  [4][DEB];
  bit debh [4][HOLD+1];
  bit deb_m[4];
  bit last_raw[4];

  function automatic logic [3:0] outs();
    return {sif.Tbl, sif.Tal, sif.Tb, sif.Ta};
  endfunction

  function automatic void check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: actual=%b required=%b", name, $time, act, req);
    end
  endfunction

  function automatic void model_reset();
    for (int ch = 0; ch < 4; ch++) begin
      last_raw[ch] = 1'b0;
      deb_m[ch]    = 1'b0;
      for (int i = 0; i < DEB; i++) s2h[ch][i] = 1'b0;
      for (int i = 0; i <= HOLD; i++) debh[ch][i] = 1'b0;
    end
  endfunction

  // Advance the model over one rising edge that samples raw vector r.
  function automatic void step(input logic [3:0] r);
    logic [3:0] e;
    bit all_diff;
    bit any_hi;
    bit nd;
    for (int ch = 0; ch < 4; ch++) begin
      all_diff = 1'b1;
      for (int i = 0; i < DEB; i++) if (s2h[ch][i] == deb_m[ch]) all_diff = 1'b0;
      any_hi = 1'b0;
      for (int i = 0; i <= HOLD; i++) any_hi = any_hi | debh[ch][i];
      e[ch] = any_hi;
      nd = all_diff ? !deb_m[ch] : deb_m[ch];
      for (int i = 0; i < DEB - 1; i++) s2h[ch][i] = s2h[ch][i+1];
      s2h[ch][DEB-1] = last_raw[ch];
      last_raw[ch]   = r[ch];
      for (int i = 0; i < HOLD; i++) debh[ch][i] = debh[ch][i+1];
      debh[ch][HOLD] = nd;
      deb_m[ch]      = nd;
    end
    exp_q.push_back(e);
  endfunction

  task automatic apply(input logic [3:0] v);
    sif.sen_a  = v[0];
    sif.sen_b  = v[1];
    sif.sen_al = v[2];
    sif.sen_bl = v[3];
  endtask

  // Called at a negedge: drive, predict the next edge, move to the next negedge.
  task automatic drive(input logic [3:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      apply(v);
      step(v);
      @(negedge clk);
    end
  endtask

  // Reset pulse between edges; outputs must clear before the next edge.
  task automatic async_pulse(input bit do_check);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    if (do_check) check("async_reset_clear", outs(), 4'b0000);
    #1 reset = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  initial begin : monitor
    logic [3:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("scoreboard", outs(), e);
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : stim
    logic [3:0] v;
    int run[4];
    reset = 1'b1;
    model_reset();
    apply(4'hF);
    repeat (3) @(negedge clk);
    check("reset_hold_outputs", outs(), 4'b0000);
    @(posedge clk);
    #2 check("reset_hold_after_edge", outs(), 4'b0000);
    @(negedge clk);
    reset = 1'b0;
    model_reset();

    // Release with all inputs high, then everything low.
    drive(4'hF, 12);
    drive(4'h0, 20);
    // Glitch on A only.
    drive(4'h1, 3);
    drive(4'h0, 12);
    // Hold stretch on B.
    drive(4'h2, 20);
    drive(4'h0, 20);
    // Gap bridging on A-left.
    drive(4'h4, 10);
    drive(4'h0, 5);
    drive(4'h4, 10);
    drive(4'h0, 20);
    // Async reset while B-left is in HOLD.
    drive(4'h8, 12);
    drive(4'h0, 10);
    check("bl_in_hold", outs(), 4'b1000);
    async_pulse(1'b1);
    drive(4'h0, 20);
    // Staggered 12-cycle pulses.
    for (int c = 0; c < 60; c++) begin
      for (int ch = 0; ch < 4; ch++) v[ch] = (c >= ch * 6) && (c < ch * 6 + 12);
      drive(v, 1);
    end
    drive(4'h0, 20);

    // Random run lengths per channel, with occasional short glitches and resets.
    v = '0;
    for (int ch = 0; ch < 4; ch++) run[ch] = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int ch = 0; ch < 4; ch++) begin
        run[ch]--;
        if (run[ch] <= 0) begin
          v[ch]   = ~v[ch];
          run[ch] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5))
                                                : int'($urandom_range(1, 25));
        end
      end
      drive(v, 1);
      if ($urandom_range(0, 399) == 0) async_pulse(1'b1);
    end
    drive(4'h0, 30);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: actual=%0d required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
